// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor.
//   - state_e        : FSM state encoding (IDLE / SHIFT / DONE)
//   - DEFAULT_WIDTH  : default operand width
//   - cnt_width()    : width of a counter that must hold 0..w without wrapping
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bits needed to count from 0 up to and including w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//   One-bit combinational subtractor: computes a - b - bin.
//   Ports:
//     a    in  : minuend bit
//     b    in  : subtrahend bit
//     bin  in  : borrow in from the less significant bit
//     d    out : difference bit
//     bout out : borrow out to the more significant bit
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // A borrow is needed whenever the bits being taken away (b, bin)
    // outweigh the minuend bit.
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor, LSB first, one bit per clock.
//   A start in IDLE captures a/b; WIDTH SHIFT cycles later the FSM enters
//   DONE for one cycle with diff = (a - b) mod 2^WIDTH and borrow_out = (a < b).
//   Ports:
//     clk        in  : clock, rising edge
//     rst_n      in  : synchronous active-low reset
//     start      in  : begin an operation (only honoured in IDLE)
//     a, b       in  : WIDTH-bit unsigned minuend / subtrahend
//     busy       out : high while bits are being processed
//     done       out : one-cycle pulse, diff/borrow_out freshly valid
//     diff       out : registered result, held until the next DONE
//     borrow_out out : registered final borrow, held until the next DONE
//   WIDTH legal range: 2..32.
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = cnt_width(WIDTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;     // minuend, shifts right
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;     // subtrahend, shifts right
    // Only WIDTH-1 partial bits need storing: the final bit is combined
    // with them directly on the edge that enters DONE.
    logic [WIDTH-2:0]   res_q,    res_d;
    logic               bor_q,    bor_d;      // running borrow
    logic [CNT_W-1:0]   cnt_q,    cnt_d;      // bits processed so far
    logic [WIDTH-1:0]   diff_q,   diff_d;
    logic               bout_q,   bout_d;

    // ------------------------------------------------------------------
    // Per-bit arithmetic on the current LSBs
    // ------------------------------------------------------------------
    logic fs_d;
    logic fs_bout;

    full_subtractor u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (bor_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // New difference bit enters from the MSB side; after WIDTH steps the
    // first bit produced has walked down to bit 0.
    logic [WIDTH-1:0] res_shift;
    assign res_shift = {fs_d, res_q};

    logic last_bit;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        bor_d   = bor_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                end
            end

            SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_shift[WIDTH-1:1];
                bor_d  = fs_bout;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    // Results are only published on the way into DONE,
                    // so they stay stable for a whole operation.
                    state_d = DONE;
                    diff_d  = res_shift;
                    bout_d  = fs_bout;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers; reset takes priority, so start is ignored while rst_n=0
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            bor_q   <= bor_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: pure decodes of registered state
    // ------------------------------------------------------------------
    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: the minuend, unsigned, captured on the accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: the subtrahend, unsigned, captured on the accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in SHIFT.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking that diff and borrow_out are valid.
REQ-009 The block SHALL have port diff, output, WIDTH bits: the result (a - b) mod 2^WIDTH.
REQ-010 The block SHALL have port borrow_out, output, 1 bit: the final borrow; it is 1 exactly when a < b.

Function
REQ-011 The block SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-012 The FSM SHALL make these transitions:
- IDLE to SHIFT on an edge with start=1.
- SHIFT to DONE after exactly WIDTH bit steps.
- DONE to IDLE unconditionally on the next edge.
REQ-013 On accepting start, the block SHALL perform all of the following on that edge:
- load a and b into internal shift registers;
- clear the borrow flip-flop;
- clear the bit counter to 0.
REQ-014 Each SHIFT edge SHALL process the current LSBs a0, b0 and the stored borrow bin, LSB first:
- difference bit d = a0 ^ b0 ^ bin;
- next borrow = (~a0 & b0) | (~a0 & bin) | (b0 & bin);
- d is shifted into the result register from the MSB side;
- both operand registers shift right by one.
REQ-015 Latency SHALL be fixed: start is sampled at edge 0, bits are processed at edges 1..WIDTH, and done=1 during the cycle following edge WIDTH.
REQ-016 done SHALL be high for exactly one cycle per accepted start and never while busy=1.
REQ-017 diff and borrow_out SHALL update only when the FSM enters DONE.
REQ-018 diff and borrow_out SHALL hold their values until the next DONE.
REQ-019 start asserted in SHIFT or DONE SHALL be ignored; it is neither queued nor allowed to disturb the operation in progress.
REQ-020 start asserted in the first IDLE cycle after DONE SHALL be accepted, so back-to-back operations take WIDTH+2 cycles each.
REQ-021 Changes on a or b after the accepted start SHALL NOT affect the result.
REQ-022 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force the following on that edge:
- state to IDLE;
- busy, done, diff and borrow_out to 0;
- the counter, borrow flip-flop and shift registers to 0.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-025 start SHALL be ignored on any edge where rst_n=0.
REQ-026 The first start SHALL be accepted on the first edge with rst_n=1.

Structure
REQ-027 A shared package serial_sub_pkg SHALL hold the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-028 The per-bit arithmetic SHALL be a combinational sub-module full_subtractor with ports a, b, bin, d and bout, instantiated once.
REQ-029 The top level SHALL contain the FSM, counter, shift registers and borrow flip-flop.

Verification
REQ-030 With WIDTH=8, a=100, b=37 and a start pulse, the bench SHALL check diff=63 and borrow_out=0, with done exactly 8 cycles after the start edge, and busy high for 8 cycles.
REQ-031 With a=5, b=9, the bench SHALL check diff=252 and borrow_out=1; with a=0, b=1, it SHALL check diff=255 and borrow_out=1.
REQ-032 With a=0, b=0, the bench SHALL check diff=0 and borrow_out=0; with a=255, b=255, it SHALL check diff=0 and borrow_out=0.
REQ-033 Start a=200, b=50, then at cycle 3 pulse start with a=1, b=2; the bench SHALL check a single done with diff=150 and no second done.
REQ-034 Start a=10, b=3, then assert rst_n=0 at cycle 4; the bench SHALL check no done and all outputs 0. A following start with a=10, b=3 SHALL yield diff=7.
REQ-035 Hold start high continuously for 3 operations; the bench SHALL check done spaced every 10 cycles (WIDTH+2). A random sweep of 1000 operand pairs SHALL match (a-b) mod 256 and (a<b).
